// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU control codes and sequencer FSM encoding for the EX-stage MUL sequencer.
package alu_mul_sequencer_pkg;

  localparam logic [2:0] ALU_ADDI = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MUL  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_ADD  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_iter_core.sv
// Iterative shift-add multiplier datapath: retires STEP multiplier bits per step, keeps low DATA_W bits.
module mul_iter_core #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STEP   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic [DATA_W-1:0] acc_o,
  output logic              done_o
);

  localparam int unsigned N_STEPS = DATA_W / STEP;
  localparam int unsigned CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int unsigned IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] step_sum;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // One iteration: add each set low multiplier bit's shifted multiplicand.
  always_comb begin
    step_sum = acc_q;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (mplier_q[IDX_W'(i)]) begin
        step_sum = step_sum + (mcand_q << i);
      end
    end
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
      cnt_d    = '0;
    end else if (load_i) begin
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << STEP;
      mplier_d = mplier_q >> STEP;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  assign acc_o  = acc_q;
  assign done_o = (cnt_q == CNT_W'(N_STEPS - 1));

endmodule

// File: rtl/alu_mul_sequencer.sv
// EX-stage controller: single-cycle ALU ops, multi-cycle MUL with pipeline stall.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STEP   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [2:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] result_o,
  output logic              result_valid_o,
  output logic              stall_o,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic              core_load, core_clear, core_step, core_done;
  logic [DATA_W-1:0] core_acc;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] result_c;
  logic              result_valid_c, stall_c, busy_c;

  mul_iter_core #(
    .DATA_W (DATA_W),
    .STEP   (STEP)
  ) u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (core_load),
    .clear_i  (core_clear),
    .step_i   (core_step),
    .mcand_i  (data1_i),
    .mplier_i (data2_i),
    .acc_o    (core_acc),
    .done_o   (core_done)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Single-cycle ops; reserved codes produce zero.
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      ALU_ADDI, ALU_ADD: alu_res = data1_i + data2_i;
      ALU_SUB:           alu_res = data1_i - data2_i;
      ALU_AND:           alu_res = data1_i & data2_i;
      ALU_OR:            alu_res = data1_i | data2_i;
      default:           alu_res = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    result_c       = '0;
    result_valid_c = 1'b0;
    stall_c        = 1'b0;
    busy_c         = 1'b0;
    core_load      = 1'b0;
    core_clear     = 1'b0;
    core_step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          if (ALUCtrl_i == ALU_MUL) begin
            stall_c   = 1'b1;
            core_load = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            result_c       = alu_res;
            result_valid_c = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        stall_c = 1'b1;
        busy_c  = 1'b1;
        if (flush_i) begin
          core_clear = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          core_step = 1'b1;
          if (core_done) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // The stalled MUL is still presented here, so inputs are ignored.
        busy_c         = 1'b1;
        result_c       = core_acc;
        result_valid_c = !flush_i;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is held.
  assign result_o       = rst_i ? result_c : '0;
  assign result_valid_o = rst_i & result_valid_c;
  assign stall_o        = rst_i & stall_c;
  assign busy_o         = rst_i & busy_c;

endmodule
